cpu_bus_arbiter: RTL and testbench

CPU_BUS_ARBITER -- requirements
Module: cpu_bus_arbiter

---
 rtl/cpu_bus_arbiter_pkg.sv | 40 ++++
 rtl/cpu_bus_arbiter_if.sv | 32 +++
 rtl/cpu_bus_arbiter_arb_tag_fifo.sv | 110 +++++++++++
 rtl/cpu_bus_arbiter.sv | 142 ++++++++++++++
 tb/tb_cpu_bus_arbiter.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// cpu_bus_arbiter_pkg
// Shared types for the CPU bus arbiter slice: the owner encoding used by the
// grant logic and the tag FIFO, the tag record stored per outstanding
// transaction, bus widths, and the fixed-priority grant helper.
//
// Optional feature macro: ARB_FLUSH_DISCARD_EN
//    When defined, each tag carries a discard bit that lets a pipeline flush
//    silently swallow responses to instruction fetches already on the bus.
// -----------------------------------------------------------------------------
package cpu_bus_arbiter_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int SIZE_W = 2;

   // Which master a transaction belongs to.
   typedef enum logic {
      OWN_INST = 1'b0,
      OWN_DATA = 1'b1
   } owner_e;

`ifdef ARB_FLUSH_DISCARD_EN
   // One entry per accepted address phase, waiting for its data phase.
   typedef struct packed {
      owner_e owner;
      logic   discard;
   } tag_t;
`else
   typedef struct packed {
      owner_e owner;
   } tag_t;
`endif

   // Fixed priority: loads/stores beat instruction fetch whenever both ask.
   function automatic owner_e pick_owner(input logic data_req);
      return data_req ? OWN_DATA : OWN_INST;
   endfunction

endpackage

// File: rtl/cpu_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// cpu_bus_arbiter_if
// One sram-like port: request channel (req/wr/size/addr/wdata) driven by the
// master, address and data handshakes plus read data driven by the slave.
//
// Modports:
//    master : drives req, wr, size, addr, wdata; receives addr_ok, data_ok, rdata
//    slave  : the mirror image
// -----------------------------------------------------------------------------
interface cpu_bus_arbiter_if;
   import cpu_bus_arbiter_pkg::*;

   logic              req;
   logic              wr;
   logic [SIZE_W-1:0] size;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              addr_ok;
   logic              data_ok;
   logic [DATA_W-1:0] rdata;

   modport master (
      output req, wr, size, addr, wdata,
      input  addr_ok, data_ok, rdata
   );

   modport slave (
      input  req, wr, size, addr, wdata,
      output addr_ok, data_ok, rdata
   );

endinterface

// File: rtl/cpu_bus_arbiter_arb_tag_fifo.sv
// -----------------------------------------------------------------------------
// arb_tag_fifo
// In-order record of which master owns each accepted-but-unanswered bus
// transaction. The arbiter pushes on every address handshake and pops on every
// data handshake, so the head always names the master the current response
// belongs to.
//
// Parameters:
//    OST_DEPTH  : entries, power of two in 2..8
// Ports:
//    clk, resetn     : clock, asynchronous active-low reset
//    push, push_tag  : write a tag at the tail (ignored when full)
//    pop             : drop the head (ignored when empty)
//    flush_mark      : mark every live instruction-owned entry as discard
//                      (only acts when ARB_FLUSH_DISCARD_EN is defined)
//    full, empty     : occupancy flags
//    head            : tag at the read pointer
// -----------------------------------------------------------------------------
module arb_tag_fifo
   import cpu_bus_arbiter_pkg::*;
#(
   parameter int OST_DEPTH = 2
) (
   input  logic clk,
   input  logic resetn,
   input  logic push,
   input  tag_t push_tag,
   input  logic pop,
   input  logic flush_mark,
   output logic full,
   output logic empty,
   output tag_t head
);

   localparam int PTR_W = (OST_DEPTH > 1) ? $clog2(OST_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   tag_t             mem_q [OST_DEPTH];
   tag_t             mem_d [OST_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_en;
   logic             pop_en;

   assign full    = (count_q == CNT_W'(OST_DEPTH));
   assign empty   = (count_q == '0);
   assign head    = mem_q[rd_ptr_q];
   assign push_en = push && !full;
   assign pop_en  = pop && !empty;

`ifdef ARB_FLUSH_DISCARD_EN
   logic [PTR_W-1:0] offset;
`else
   logic unused_flush_mark;
   assign unused_flush_mark = flush_mark;
`endif

   // Next-state for storage, pointers and count. Pointers are PTR_W bits wide
   // and the depth is a power of two, so plain increment wraps at the depth.
   // Flush marking is applied before the push so a tag entering in the same
   // cycle as a flush starts out clean.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
`ifdef ARB_FLUSH_DISCARD_EN
      offset   = '0;
      if (flush_mark) begin
         for (int i = 0; i < OST_DEPTH; i++) begin
            offset = PTR_W'(i) - rd_ptr_q;
            if (({1'b0, offset} < count_q) && (mem_q[i].owner == OWN_INST)) begin
               mem_d[i].discard = 1'b1;
            end
         end
      end
`endif
      if (push_en) begin
         mem_d[wr_ptr_q] = push_tag;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop_en) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push_en, pop_en})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // State registers; reset abandons every outstanding tag.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < OST_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/cpu_bus_arbiter.sv
// -----------------------------------------------------------------------------
// cpu_bus_arbiter
// Merges the instruction-fetch and load/store sram-like ports onto a single
// sram-like bus. Data has fixed priority over inst; once a request is shown on
// the bus without an address handshake, the owner is locked until it is
// accepted so a held request is never re-steered. Responses return in order
// and are steered to the right master by a tag FIFO with zero added latency.
//
// Parameters:
//    OST_DEPTH : maximum outstanding accepted transactions (power of two 2..8)
// Ports:
//    clk, resetn : clock, asynchronous active-low reset
//    flush       : exception/eret flush pulse from writeback
//    inst        : fetch port (slave side of the interface)
//    data        : load/store port (slave side of the interface)
//    bus         : shared downstream port (master side of the interface)
//
// Optional feature macro: ARB_FLUSH_DISCARD_EN
//    When defined, flush marks every outstanding fetch so its response is
//    consumed from the bus without raising inst.data_ok. When undefined, flush
//    is ignored and every response is delivered.
// -----------------------------------------------------------------------------
module cpu_bus_arbiter
   import cpu_bus_arbiter_pkg::*;
#(
   parameter int OST_DEPTH = 2
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              flush,
   cpu_bus_arbiter_if.slave  inst,
   cpu_bus_arbiter_if.slave  data,
   cpu_bus_arbiter_if.master bus
);

   owner_e owner_q, owner_d;
   logic   lock_q, lock_d;
   owner_e cur_owner;
   logic   owner_req;
   logic   fifo_full;
   logic   fifo_empty;
   tag_t   fifo_head;
   tag_t   push_tag;
   logic   push;
   logic   pop;
   logic   deliver;
   logic   flush_mark;

   // Owner selection: a locked owner wins outright, otherwise the fixed
   // priority grant is decided fresh this cycle.
   always_comb begin
      cur_owner = lock_q ? owner_q : pick_owner(data.req);
      owner_req = (cur_owner == OWN_DATA) ? data.req : inst.req;
   end

   // Downstream request mux. Requests are masked while the tag FIFO is full
   // so an accepted address always has a slot to record its owner. All bus
   // outputs are held at zero while reset is asserted.
   always_comb begin
      bus.req   = 1'b0;
      bus.wr    = 1'b0;
      bus.size  = '0;
      bus.addr  = '0;
      bus.wdata = '0;
      if (resetn) begin
         bus.req = owner_req && !fifo_full;
         if (cur_owner == OWN_DATA) begin
            bus.wr    = data.wr;
            bus.size  = data.size;
            bus.addr  = data.addr;
            bus.wdata = data.wdata;
         end else begin
            bus.wr    = inst.wr;
            bus.size  = inst.size;
            bus.addr  = inst.addr;
            bus.wdata = inst.wdata;
         end
      end
   end

   assign push         = bus.req && bus.addr_ok;
   assign inst.addr_ok = push && (cur_owner == OWN_INST);
   assign data.addr_ok = push && (cur_owner == OWN_DATA);

   // Tag for the transaction being accepted; it always enters un-discarded.
   always_comb begin
      push_tag       = '0;
      push_tag.owner = cur_owner;
   end

   // A data handshake with nothing outstanding is a stray and is dropped here
   // so it neither pops the FIFO nor reaches either master.
   assign pop = resetn && bus.data_ok && !fifo_empty;

`ifdef ARB_FLUSH_DISCARD_EN
   assign flush_mark = flush;
   assign deliver    = pop && !fifo_head.discard;
`else
   logic unused_flush;
   assign unused_flush = flush;
   assign flush_mark   = 1'b0;
   assign deliver      = pop;
`endif

   assign inst.data_ok = deliver && (fifo_head.owner == OWN_INST);
   assign data.data_ok = deliver && (fifo_head.owner == OWN_DATA);
   assign inst.rdata   = inst.data_ok ? bus.rdata : '0;
   assign data.rdata   = data.data_ok ? bus.rdata : '0;

   // Lock holds exactly while a request sits on the bus unaccepted; the
   // handshake cycle clears it so the next grant is free to change.
   always_comb begin
      lock_d  = bus.req && !bus.addr_ok;
      owner_d = cur_owner;
   end

   // Owner/lock registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         owner_q <= OWN_INST;
         lock_q  <= 1'b0;
      end else begin
         owner_q <= owner_d;
         lock_q  <= lock_d;
      end
   end

   arb_tag_fifo #(
      .OST_DEPTH (OST_DEPTH)
   ) u_tag_fifo (
      .clk        (clk),
      .resetn     (resetn),
      .push       (push),
      .push_tag   (push_tag),
      .pop        (pop),
      .flush_mark (flush_mark),
      .full       (fifo_full),
      .empty      (fifo_empty),
      .head       (fifo_head)
   );

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cpu_bus_arbiter
// Drives both masters and the bus slave, keeps a queue-based reference model
// of outstanding transactions, and compares each cycle's DUT outputs against
// expectations queued when the stimulus was applied.
// Honours ARB_FLUSH_DISCARD_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_cpu_bus_arbiter;

   localparam int OST_DEPTH   = 2;
   localparam int RAND_CYCLES = 600;
   localparam logic [31:0] WMASK = 32'hA5A5_5A5A;

   logic clk = 1'b0;
   logic resetn;
   logic flush;

   always #5 clk = ~clk;

   cpu_bus_arbiter_if inst_if ();
   cpu_bus_arbiter_if data_if ();
   cpu_bus_arbiter_if bus_if ();

   cpu_bus_arbiter #(
      .OST_DEPTH (OST_DEPTH)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .flush  (flush),
      .inst   (inst_if),
      .data   (data_if),
      .bus    (bus_if)
   );

   typedef struct {
      int owner;
      bit discard;
   } model_tag_t;

   typedef struct {
      bit          rst;
      bit          bus_req;
      logic [31:0] bus_addr;
      logic        bus_wr;
      logic [1:0]  bus_size;
      logic [31:0] bus_wdata;
      bit          inst_addr_ok;
      bit          data_addr_ok;
      bit          inst_data_ok;
      bit          data_data_ok;
   } cyc_exp_t;

   typedef struct {
      int          owner;
      logic [31:0] rdata;
   } resp_t;

   model_tag_t m_tags[$];
   int         m_held = -1;
   bit         hs_inst;
   bit         hs_data;
   cyc_exp_t   cyc_q[$];
   resp_t      resp_q[$];
   int         errors = 0;
   int         checks = 0;

   // One comparison: counts it, and reports a FAIL line on mismatch.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Drives one cycle of inputs, derives the expected outputs from the
   // transaction-level model, queues them for the monitor, then advances to
   // just after the next rising edge.
   task automatic applyStimulus(input logic ir, input logic [31:0] ia,
                                input logic dr, input logic [31:0] da,
                                input logic aok, input logic dok, input logic [31:0] rd,
                                input logic fl, input logic rn);
      cyc_exp_t   e;
      model_tag_t t;
      resp_t      r;
      int         who;
      bit         full;
      bit         hs;

      inst_if.req   = ir;
      inst_if.addr  = ia;
      inst_if.wr    = ia[2];
      inst_if.size  = ia[1:0];
      inst_if.wdata = ia ^ WMASK;
      data_if.req   = dr;
      data_if.addr  = da;
      data_if.wr    = da[2];
      data_if.size  = da[1:0];
      data_if.wdata = da ^ WMASK;
      bus_if.addr_ok = aok;
      bus_if.data_ok = dok;
      bus_if.rdata   = rd;
      flush  = fl;
      resetn = rn;

      e       = '{default: '0};
      hs_inst = 1'b0;
      hs_data = 1'b0;
      if (!rn) begin
         e.rst = 1'b1;
         m_tags.delete();
         m_held = -1;
      end else begin
         full = (m_tags.size() == OST_DEPTH);
         if (m_held >= 0)  who = m_held;
         else if (dr)      who = 1;
         else if (ir)      who = 0;
         else              who = -1;
         if (who == 1) begin
            e.bus_req = dr && !full;
            e.bus_addr = da; e.bus_wr = da[2]; e.bus_size = da[1:0]; e.bus_wdata = da ^ WMASK;
         end else if (who == 0) begin
            e.bus_req = ir && !full;
            e.bus_addr = ia; e.bus_wr = ia[2]; e.bus_size = ia[1:0]; e.bus_wdata = ia ^ WMASK;
         end
         hs = e.bus_req && aok;
         e.inst_addr_ok = hs && (who == 0);
         e.data_addr_ok = hs && (who == 1);
         if (dok && m_tags.size() > 0) begin
            t = m_tags.pop_front();
            if (!t.discard) begin
               r.owner = t.owner;
               r.rdata = rd;
               resp_q.push_back(r);
               e.inst_data_ok = (t.owner == 0);
               e.data_data_ok = (t.owner == 1);
            end
         end
`ifdef ARB_FLUSH_DISCARD_EN
         if (fl) begin
            foreach (m_tags[i]) begin
               if (m_tags[i].owner == 0) m_tags[i].discard = 1'b1;
            end
         end
`endif
         if (hs) begin
            t.owner   = who;
            t.discard = 1'b0;
            m_tags.push_back(t);
         end
         m_held  = (e.bus_req && !aok) ? who : -1;
         hs_inst = e.inst_addr_ok;
         hs_data = e.data_addr_ok;
      end
      cyc_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   // Monitor: samples mid-cycle, pops the cycle expectation and the response
   // scoreboard, and compares.
   initial begin : monitor
      cyc_exp_t e;
      resp_t    r;
      forever begin
         @(negedge clk);
         if (cyc_q.size() != 0) begin
            e = cyc_q.pop_front();
            checkOutput("bus_req", bus_if.req, e.bus_req);
            if (e.bus_req) begin
               checkOutput("bus_addr", bus_if.addr, e.bus_addr);
               checkOutput("bus_wr", bus_if.wr, e.bus_wr);
               checkOutput("bus_size", bus_if.size, e.bus_size);
               checkOutput("bus_wdata", bus_if.wdata, e.bus_wdata);
            end
            checkOutput("inst_addr_ok", inst_if.addr_ok, e.inst_addr_ok);
            checkOutput("data_addr_ok", data_if.addr_ok, e.data_addr_ok);
            checkOutput("inst_data_ok", inst_if.data_ok, e.inst_data_ok);
            checkOutput("data_data_ok", data_if.data_ok, e.data_data_ok);
            if (e.rst) begin
               checkOutput("rst_bus_addr", bus_if.addr, 32'h0);
               checkOutput("rst_bus_wdata", bus_if.wdata, 32'h0);
               checkOutput("rst_inst_rdata", inst_if.rdata, 32'h0);
               checkOutput("rst_data_rdata", data_if.rdata, 32'h0);
            end
            if (inst_if.data_ok === 1'b1 && resp_q.size() > 0) begin
               r = resp_q.pop_front();
               checkOutput("inst_resp_owner", 32'd0, r.owner);
               checkOutput("inst_rdata", inst_if.rdata, r.rdata);
            end
            if (data_if.data_ok === 1'b1 && resp_q.size() > 0) begin
               r = resp_q.pop_front();
               checkOutput("data_resp_owner", 32'd1, r.owner);
               checkOutput("data_rdata", data_if.rdata, r.rdata);
            end
            checkOutput("resp_undelivered", resp_q.size(), 32'd0);
            resp_q.delete();
         end
      end
   end

   // Safety net so the run always ends.
   initial begin : watchdog
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed scenarios followed by randomized traffic.
   initial begin : stimulus
      logic        i_pend, d_pend;
      logic [31:0] i_addr, d_addr;
      logic        rn;

      resetn = 1'b0;
      flush  = 1'b0;
      inst_if.req = 1'b0; inst_if.wr = 1'b0; inst_if.size = '0; inst_if.addr = '0; inst_if.wdata = '0;
      data_if.req = 1'b0; data_if.wr = 1'b0; data_if.size = '0; data_if.addr = '0; data_if.wdata = '0;
      bus_if.addr_ok = 1'b0; bus_if.data_ok = 1'b0; bus_if.rdata = '0;
      @(posedge clk);
      #1;

      // Reset with requests and handshakes already asserted: everything stays low.
      applyStimulus(1, 32'h1fc0_0000, 1, 32'h0000_0010, 1, 1, 32'h1234_5678, 0, 0);
      applyStimulus(0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 0, 0);
      // Stray data handshake on an empty FIFO.
      applyStimulus(0, 32'h0, 0, 32'h0, 0, 1, 32'h5555_5555, 0, 1);

      // Simultaneous requests: data first, inst next cycle, responses in that order.
      applyStimulus(1, 32'h1fc0_0000, 1, 32'h0000_0010, 1, 0, 32'h0, 0, 1);
      applyStimulus(1, 32'h1fc0_0000, 0, 32'h0, 1, 0, 32'h0, 0, 1);
      applyStimulus(0, 32'h0, 0, 32'h0, 0, 1, 32'hAAAA_0001, 0, 1);
      applyStimulus(0, 32'h0, 0, 32'h0, 0, 1, 32'hAAAA_0002, 0, 1);

      // Held inst request is not re-steered when data arrives.
      applyStimulus(1, 32'h1fc0_0004, 0, 32'h0, 0, 0, 32'h0, 0, 1);
      repeat (3) applyStimulus(1, 32'h1fc0_0004, 1, 32'h0000_0020, 0, 0, 32'h0, 0, 1);
      applyStimulus(1, 32'h1fc0_0004, 1, 32'h0000_0020, 1, 0, 32'h0, 0, 1);
      applyStimulus(0, 32'h0, 1, 32'h0000_0020, 1, 0, 32'h0, 0, 1);

      // FIFO full masks bus_req; one response frees a slot for the next cycle.
      applyStimulus(1, 32'h1fc0_0008, 0, 32'h0, 1, 0, 32'h0, 0, 1);
      applyStimulus(1, 32'h1fc0_0008, 0, 32'h0, 1, 1, 32'hBBBB_0001, 0, 1);
      // Push and pop together at one outstanding, then drain.
      applyStimulus(1, 32'h1fc0_0008, 0, 32'h0, 1, 1, 32'hBBBB_0002, 0, 1);
      applyStimulus(0, 32'h0, 0, 32'h0, 0, 1, 32'hBBBB_0003, 0, 1);

      // Two fetches outstanding, flush, then both responses.
      applyStimulus(1, 32'h1fc0_0010, 0, 32'h0, 1, 0, 32'h0, 0, 1);
      applyStimulus(1, 32'h1fc0_0014, 0, 32'h0, 1, 0, 32'h0, 0, 1);
      applyStimulus(0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 1, 1);
      applyStimulus(0, 32'h0, 0, 32'h0, 0, 1, 32'hDEAD_BEEF, 0, 1);
      applyStimulus(0, 32'h0, 0, 32'h0, 0, 1, 32'hDEAD_BEEF, 0, 1);
      applyStimulus(0, 32'h0, 0, 32'h0, 0, 1, 32'hDEAD_0003, 0, 1);

      // Reset pulse mid-read, then a stray response, then normal traffic.
      applyStimulus(1, 32'h1fc0_0020, 0, 32'h0, 1, 0, 32'h0, 0, 1);
      applyStimulus(0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 0, 0);
      applyStimulus(0, 32'h0, 0, 32'h0, 0, 1, 32'hCCCC_0001, 0, 1);
      applyStimulus(1, 32'h1fc0_0024, 0, 32'h0, 1, 0, 32'h0, 0, 1);
      applyStimulus(0, 32'h0, 0, 32'h0, 0, 1, 32'hCCCC_0002, 0, 1);

      // Randomized traffic from protocol-respecting masters.
      i_pend = 1'b0; d_pend = 1'b0; i_addr = '0; d_addr = '0;
      for (int c = 0; c < RAND_CYCLES; c++) begin
         if (!i_pend && $urandom_range(0, 2) == 0) begin
            i_pend = 1'b1;
            i_addr = $urandom;
         end
         if (!d_pend && $urandom_range(0, 2) == 0) begin
            d_pend = 1'b1;
            d_addr = $urandom;
         end
         rn = ($urandom_range(0, 199) != 0);
         applyStimulus(i_pend, i_addr, d_pend, d_addr,
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0), $urandom,
                       1'($urandom_range(0, 15) == 0), rn);
         if (hs_inst || !rn) i_pend = 1'b0;
         if (hs_data || !rn) d_pend = 1'b0;
      end

      // Drain idle cycles so the monitor consumes every expectation.
      repeat (2) applyStimulus(0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 0, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
